signed_updown_bounded_counter: RTL and testbench
================================================

Name: signed_updown_bounded_counter

Overview:
- Parametrised signed up/down counter with programmable step and synchronous load.
- Bounds are compile-time; at a bound the counter either wraps modularly or saturates, selected at run time by a mode input.
- Flags report bound events: a registered one-cycle event pulse plus sticky overflow and underflow bits.
- Next-generation general-purpose counter for timing, position and accumulator-style uses across the design.

Parameters:
- WIDTH, 4, counter width in bits; Q is two's complement.
- SW, 2, width of the unsigned step magnitude input STEP.
- CMIN, -8, lowest legal count; signed, must fit in WIDTH bits.
- CMAX, 7, highest legal count; must satisfy CMAX > CMIN and (CMAX-CMIN+1) >= 2^SW - 1.

Ports:
- C  input  1  clock; rising edge active.
- CLR  input  1  asynchronous reset, active-high.
- CE  input  1  count enable.
- UP  input  1  direction: 1 counts up, 0 counts down.
- STEP  input  SW  unsigned step magnitude; 0 holds the count.
- SAT  input  1  mode: 1 saturates at bounds, 0 wraps.
- LD  input  1  synchronous load.
- D  input  WIDTH  signed load value.
- FCLR  input  1  synchronous clear of the sticky flags.
- Q  output  WIDTH  signed count.
- EVT  output  1  one-cycle pulse: the previous update crossed a bound.
- OVF  output  1  sticky flag: an up-count exceeded CMAX.
- UDF  output  1  sticky flag: a down-count went below CMIN.

Behaviour:
- Reset: CLR high forces Q=0 (or CMIN if 0 is outside [CMIN,CMAX]), EVT=0, OVF=0, UDF=0, immediately and independent of C. It holds while CLR is high. It is effective mid-operation and overrides every other input.
- Priority on each rising C edge: LD > CE count > hold.
- Load:
  - Q <= D, clamped to CMIN/CMAX if D is outside the range.
  - Load never sets EVT, OVF or UDF.
- Count (CE=1, LD=0):
  - Compute N = Q ± STEP in WIDTH+SW+1 bits, sign-extended. No intermediate overflow is permitted.
  - If CMIN <= N <= CMAX: Q <= N.
  - If N > CMAX: SAT=1 gives Q <= CMAX; SAT=0 gives Q <= N - (CMAX-CMIN+1). Either way EVT<=1 and OVF<=1.
  - If N < CMIN: SAT=1 gives Q <= CMIN; SAT=0 gives Q <= N + (CMAX-CMIN+1). Either way EVT<=1 and UDF<=1.
  - Landing exactly on a bound is not an event.
  - Saturated at a bound and pushing further: Q stays put, but EVT pulses again and the sticky flag re-sets. Every cycle at the bound is flagged.
  - STEP=0 with CE=1: Q unchanged, no event.
- EVT:
  - Registered; high for exactly one cycle following the edge whose update crossed a bound.
  - Deasserted on every other edge, including load and hold cycles.
- Sticky flags:
  - FCLR clears OVF and UDF on the next edge.
  - If a crossing and FCLR occur on the same edge, the set wins.
  - FCLR does not affect Q or EVT.
- Latency: all outputs change one edge after the inputs are sampled. No combinational path from inputs to outputs.
- Q is always within [CMIN,CMAX] outside of reset.
- Inputs are synchronous to C. CLR deassertion must meet recovery/removal timing; no internal synchronizer.

Test Plan:
- Reset check: assert CLR mid-count (Q=5) between clock edges -> Q=0, EVT=0, OVF=0, UDF=0 immediately, with no clock edge.
- Wrap up: defaults, SAT=0, UP=1, STEP=1, CE=1 from Q=6 -> sequence 7, -8, -7. EVT high only in the cycle after the 7 -> -8 step; OVF set and staying 1.
- Step crossing: SAT=0, UP=0, STEP=3, Q=-6 -> Q=7 (-9+16); UDF=1, EVT pulse. Then SAT=1, STEP=3 from Q=-6 -> Q=-8, UDF=1. A further down-count keeps Q=-8 with EVT pulsing each cycle.
- Load priority and clamping:
  - LD=1 with CE=1, D=3 -> Q=3, no EVT.
  - Bench with CMIN=-5, CMAX=5: D=-8 loads as -5, D=7 loads as 5.
- Flag clear race:
  - Set OVF, then FCLR=1 alone -> OVF=0 next cycle.
  - FCLR=1 on the same edge as an up-overflow -> OVF stays 1.
- Hold cases:
  - CE=0 for 4 cycles at Q=2 -> Q=2, EVT=0.
  - CE=1 with STEP=0 -> Q=2, EVT=0.

Source files
------------

// File: rtl/signed_updown_bounded_counter.sv
// Signed up/down counter with programmable step, synchronous load and
// compile-time bounds; wraps or saturates at a bound under run-time control.
module signed_updown_bounded_counter #(
  parameter int WIDTH = 4,
  parameter int SW    = 2,
  parameter int CMIN  = -8,
  parameter int CMAX  = 7
) (
  input  logic                    C,
  input  logic                    CLR,
  input  logic                    CE,
  input  logic                    UP,
  input  logic [SW-1:0]           STEP,
  input  logic                    SAT,
  input  logic                    LD,
  input  logic signed [WIDTH-1:0] D,
  input  logic                    FCLR,
  output logic signed [WIDTH-1:0] Q,
  output logic                    EVT,
  output logic                    OVF,
  output logic                    UDF
);

  // Extended width holds Q +/- STEP without intermediate overflow.
  localparam int EW = WIDTH + SW + 1;

  typedef logic signed [EW-1:0]    ext_t;
  typedef logic signed [WIDTH-1:0] cnt_t;

  localparam ext_t MIN_E = ext_t'(CMIN);
  localparam ext_t MAX_E = ext_t'(CMAX);
  localparam ext_t RNG_E = ext_t'(CMAX - CMIN + 1);
  localparam cnt_t RST_Q = cnt_t'(((CMIN <= 0) && (CMAX >= 0)) ? 0 : CMIN);

  cnt_t q_q, q_d;
  logic evt_q, evt_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  ext_t q_ext, step_ext, d_ext, n_ext;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else tree can leave a value unassigned and infer a latch.
    q_ext    = ext_t'(q_q);
    step_ext = ext_t'(STEP);
    d_ext    = ext_t'(D);
    n_ext    = UP ? (q_ext + step_ext) : (q_ext - step_ext);

    q_d   = q_q;
    evt_d = 1'b0;
    ovf_d = ovf_q & ~FCLR;
    udf_d = udf_q & ~FCLR;

    if (LD) begin
      if (d_ext > MAX_E)      q_d = cnt_t'(MAX_E);
      else if (d_ext < MIN_E) q_d = cnt_t'(MIN_E);
      else                    q_d = D;
    end else if (CE) begin
      if (n_ext > MAX_E) begin
        q_d   = SAT ? cnt_t'(MAX_E) : cnt_t'(n_ext - RNG_E);
        evt_d = 1'b1;
        ovf_d = 1'b1;
      end else if (n_ext < MIN_E) begin
        q_d   = SAT ? cnt_t'(MIN_E) : cnt_t'(n_ext + RNG_E);
        evt_d = 1'b1;
        udf_d = 1'b1;
      end else begin
        q_d = cnt_t'(n_ext);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      q_q   <= RST_Q;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      evt_q <= evt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign Q   = q_q;
  assign EVT = evt_q;
  assign OVF = ovf_q;
  assign UDF = udf_q;

endmodule

// File: tb/tb_signed_updown_bounded_counter.sv
// Directed vector bench for signed_updown_bounded_counter: default bounds
// [-8,7] plus a second instance with bounds [-5,5] for load clamping.
module tb_signed_updown_bounded_counter;

  logic              C = 1'b0;
  logic              CLR = 1'b1;
  logic              CE = 1'b0, UP = 1'b0, SAT = 1'b0, LD = 1'b0, FCLR = 1'b0;
  logic [1:0]        STEP = 2'd0;
  logic signed [3:0] D = 4'sd0;
  logic signed [3:0] q1, q2;
  logic              evt1, ovf1, udf1, evt2, ovf2, udf2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int ld, ce, up, sat, fclr, step, d;
    int q, evt, ovf, udf;
  } vec_t;

  vec_t vecs[$];

  always #5 C = ~C;

  signed_updown_bounded_counter dut1 (
    .C(C), .CLR(CLR), .CE(CE), .UP(UP), .STEP(STEP), .SAT(SAT), .LD(LD),
    .D(D), .FCLR(FCLR), .Q(q1), .EVT(evt1), .OVF(ovf1), .UDF(udf1)
  );

  signed_updown_bounded_counter #(.WIDTH(4), .SW(2), .CMIN(-5), .CMAX(5)) dut2 (
    .C(C), .CLR(CLR), .CE(CE), .UP(UP), .STEP(STEP), .SAT(SAT), .LD(LD),
    .D(D), .FCLR(FCLR), .Q(q2), .EVT(evt2), .OVF(ovf2), .UDF(udf2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int ld, ce, up, sat, fclr, step, d, q, evt, ovf, udf);
    vec_t v;
    v = '{ld, ce, up, sat, fclr, step, d, q, evt, ovf, udf};
    vecs.push_back(v);
  endtask

  task automatic drive(input int ld, ce, up, sat, fclr, step, d);
    LD   = ld[0];
    CE   = ce[0];
    UP   = up[0];
    SAT  = sat[0];
    FCLR = fclr[0];
    STEP = step[1:0];
    D    = d[3:0];
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic check_dut1(input string tag, input int q, evt, ovf, udf);
    check({tag, ".Q"},   int'(q1), q);
    check({tag, ".EVT"}, int'(evt1), evt);
    check({tag, ".OVF"}, int'(ovf1), ovf);
    check({tag, ".UDF"}, int'(udf1), udf);
  endtask

  initial begin
    //   ld ce up sat fclr step  d     q  evt ovf udf
    add(1, 0, 0, 0, 0, 0,  6,    6, 0, 0, 0);  // load 6
    add(0, 1, 1, 0, 0, 1,  0,    7, 0, 0, 0);  // wrap-up sequence
    add(0, 1, 1, 0, 0, 1,  0,   -8, 1, 1, 0);
    add(0, 1, 1, 0, 0, 1,  0,   -7, 0, 1, 0);
    add(1, 1, 1, 0, 0, 1,  3,    3, 0, 1, 0);  // load beats count
    add(1, 0, 0, 0, 0, 0, -6,   -6, 0, 1, 0);
    add(0, 1, 0, 0, 0, 3,  0,    7, 1, 1, 1);  // -9 wraps to 7
    add(1, 0, 0, 0, 0, 0, -6,   -6, 0, 1, 1);
    add(0, 1, 0, 1, 0, 3,  0,   -8, 1, 1, 1);  // saturate low
    add(0, 1, 0, 1, 0, 3,  0,   -8, 1, 1, 1);  // push at bound
    add(0, 1, 0, 1, 0, 1,  0,   -8, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0,  0,   -8, 0, 0, 0);  // flag clear alone
    add(1, 0, 0, 0, 0, 0,  7,    7, 0, 0, 0);
    add(0, 1, 1, 1, 1, 1,  0,    7, 1, 1, 0);  // set beats clear
    add(0, 0, 1, 1, 1, 0,  0,    7, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  2,    2, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3,  0,    2, 0, 0, 0);  // hold x4
    add(0, 0, 1, 0, 0, 3,  0,    2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0,    2, 0, 0, 0);
    add(0, 0, 0, 1, 0, 2,  0,    2, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0,  0,    2, 0, 0, 0);  // step 0 holds
    add(0, 1, 1, 0, 0, 2,  0,    4, 0, 0, 0);
    add(0, 1, 1, 0, 0, 3,  0,    7, 0, 0, 0);  // land on CMAX
    add(0, 1, 0, 0, 0, 3,  0,    4, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, -5,   -5, 0, 0, 0);
    add(0, 1, 0, 0, 0, 3,  0,   -8, 0, 0, 0);  // land on CMIN
    add(0, 1, 1, 0, 0, 3,  0,   -5, 0, 0, 0);

    // Reset state while CLR is held.
    #12;
    check_dut1("reset", 0, 0, 0, 0);
    check("reset.Q2", int'(q2), 0);
    @(negedge C);
    CLR = 1'b0;

    // Load clamping against the [-5,5] instance.
    drive(1, 0, 0, 0, 0, 0, -8); tick();
    check("clamp_lo.Q2", int'(q2), -5);
    check("clamp_lo.Q1", int'(q1), -8);
    drive(1, 0, 0, 0, 0, 0, 7);  tick();
    check("clamp_hi.Q2", int'(q2), 5);
    check("clamp_hi.Q1", int'(q1), 7);
    drive(1, 0, 0, 0, 0, 0, -3); tick();
    check("load_in.Q2", int'(q2), -3);
    check("load.EVT2", int'(evt2), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].ce, vecs[i].up, vecs[i].sat, vecs[i].fclr,
            vecs[i].step, vecs[i].d);
      tick();
      check_dut1($sformatf("vec%0d", i), vecs[i].q, vecs[i].evt, vecs[i].ovf, vecs[i].udf);
    end

    // Asynchronous reset mid-count with live flags.
    drive(1, 0, 0, 0, 0, 0, -8); tick();
    drive(0, 1, 0, 0, 0, 3, 0);  tick();
    check_dut1("prereset", 5, 1, 0, 1);
    #3;
    CLR = 1'b1;
    #1;
    check_dut1("async_reset", 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 3, 0);
    tick();
    check_dut1("reset_held", 0, 0, 0, 0);
    @(negedge C);
    CLR = 1'b0;
    tick();
    check_dut1("post_reset", 3, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
